// File: rtl/regf_write_queue_pkg.sv
// Shared register-file types: default widths and the queued write-pair record.
package regf_write_queue_pkg;
  localparam int DATA_WDT_DEF = 32;
  localparam int ADDR_WDT_DEF = 6;
  localparam int QDEPTH_DEF   = 4;

  typedef struct packed {
    logic                    en_a;
    logic                    en_b;
    logic [ADDR_WDT_DEF-1:0] addr_a;
    logic [ADDR_WDT_DEF-1:0] addr_b;
    logic [DATA_WDT_DEF-1:0] data_a;
    logic [DATA_WDT_DEF-1:0] data_b;
  } wq_entry_t;
endpackage

// File: rtl/regf_write_queue_if.sv
// Client-side write-pair and read-request bus of the register-file write queue.
interface regf_wq_if #(
  parameter int DATA_WDT = 32,
  parameter int ADDR_WDT = 6
);
  logic                i_wr_valid;
  logic                i_wr_en_a;
  logic                i_wr_en_b;
  logic [ADDR_WDT-1:0] i_wr_addr_a;
  logic [ADDR_WDT-1:0] i_wr_addr_b;
  logic [DATA_WDT-1:0] i_wr_data_a;
  logic [DATA_WDT-1:0] i_wr_data_b;
  logic                o_wr_ready;
  logic                i_rd_valid;
  logic [ADDR_WDT-1:0] i_rd_addr;
  logic                o_rd_ready;
  logic                o_rd_data_valid;
  logic [DATA_WDT-1:0] o_rd_data;

  modport master (
    output i_wr_valid, i_wr_en_a, i_wr_en_b, i_wr_addr_a, i_wr_addr_b,
           i_wr_data_a, i_wr_data_b, i_rd_valid, i_rd_addr,
    input  o_wr_ready, o_rd_ready, o_rd_data_valid, o_rd_data
  );
  modport slave (
    input  i_wr_valid, i_wr_en_a, i_wr_en_b, i_wr_addr_a, i_wr_addr_b,
           i_wr_data_a, i_wr_data_b, i_rd_valid, i_rd_addr,
    output o_wr_ready, o_rd_ready, o_rd_data_valid, o_rd_data
  );
endinterface

// File: rtl/regf_pair_fifo.sv
// Circular store of write-pair entries; all entries are exposed for forwarding.
module regf_pair_fifo
  import regf_write_queue_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wq_entry_t                    push_ent,
  input  logic                         pop,
  output wq_entry_t [QDEPTH-1:0]       ents,
  output logic      [PW-1:0]           rd_ptr,
  output logic      [CW-1:0]           count
);
  logic [PW-1:0] wr_ptr;

  // Power-of-2 depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ents   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ents[wr_ptr] <= push_ent;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/regf_write_queue.sv
// Register-file write queue: buffers write pairs, arbitrates RAM port use
// between drains and reads, and forwards queued data to reads.
module regf_write_queue
  import regf_write_queue_pkg::*;
#(
  parameter int DATA_WDT = DATA_WDT_DEF,
  parameter int ADDR_WDT = ADDR_WDT_DEF,
  parameter int QDEPTH   = QDEPTH_DEF,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic                i_clk_2x,
  input  logic                i_reset,
  regf_wq_if.slave            bus,
  output logic [ADDR_WDT-1:0] o_addr_a,
  output logic [ADDR_WDT-1:0] o_addr_b,
  output logic                o_wen,
  output logic [DATA_WDT-1:0] o_wr_data_a,
  output logic [DATA_WDT-1:0] o_wr_data_b,
  input  logic [DATA_WDT-1:0] i_rd_data_a,
  output logic [CW-1:0]       o_count
);
  wq_entry_t [QDEPTH-1:0] ents;
  wq_entry_t              push_ent, head, fe;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   full, empty, drain, rd_issue, wr_acc, same_addr;
  logic                   fwd_hit, fwd_hit_q, rd_vld_q;
  logic [DATA_WDT-1:0]    fwd_data, fwd_data_q;

  assign full     = (count == CW'(QDEPTH));
  assign empty    = (count == '0);
  assign rd_issue = !i_reset && !full && bus.i_rd_valid;
  assign drain    = !i_reset && !empty && (full || !bus.i_rd_valid);
  assign wr_acc   = !i_reset && bus.i_wr_valid && !full &&
                    (bus.i_wr_en_a || bus.i_wr_en_b);

  // Same-address pair collapses to slot b alone.
  assign same_addr = bus.i_wr_en_a && bus.i_wr_en_b &&
                     (bus.i_wr_addr_a == bus.i_wr_addr_b);
  always_comb begin
    push_ent        = '0;
    push_ent.en_a   = bus.i_wr_en_a && !same_addr;
    push_ent.en_b   = bus.i_wr_en_b;
    push_ent.addr_a = bus.i_wr_addr_a;
    push_ent.addr_b = bus.i_wr_addr_b;
    push_ent.data_a = bus.i_wr_data_a;
    push_ent.data_b = bus.i_wr_data_b;
  end

  regf_pair_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk      (i_clk_2x),
    .rst      (i_reset),
    .push     (wr_acc),
    .push_ent (push_ent),
    .pop      (drain),
    .ents     (ents),
    .rd_ptr   (rd_ptr),
    .count    (count)
  );

  assign head = ents[rd_ptr];

  // Walk oldest to youngest so the last hit wins; slot b checked after a.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fe       = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      fe = ents[rd_ptr + PW'(k)];
      if (CW'(k) < count) begin
        if (fe.en_a && fe.addr_a == bus.i_rd_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = fe.data_a;
        end
        if (fe.en_b && fe.addr_b == bus.i_rd_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = fe.data_b;
        end
      end
    end
  end

  always_ff @(posedge i_clk_2x) begin
    if (i_reset) begin
      rd_vld_q   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_vld_q   <= rd_issue;
      fwd_hit_q  <= fwd_hit;
      fwd_data_q <= fwd_data;
    end
  end

  // A single-slot entry mirrors its valid slot onto both RAM ports.
  always_comb begin
    o_wen       = 1'b0;
    o_addr_a    = '0;
    o_addr_b    = '0;
    o_wr_data_a = '0;
    o_wr_data_b = '0;
    if (drain) begin
      o_wen       = 1'b1;
      o_addr_a    = head.en_a ? head.addr_a : head.addr_b;
      o_addr_b    = head.en_b ? head.addr_b : head.addr_a;
      o_wr_data_a = head.en_a ? head.data_a : head.data_b;
      o_wr_data_b = head.en_b ? head.data_b : head.data_a;
    end else if (rd_issue) begin
      o_addr_a = bus.i_rd_addr;
    end
  end

  assign bus.o_wr_ready      = i_reset || !full;
  assign bus.o_rd_ready      = rd_issue;
  assign bus.o_rd_data_valid = rd_vld_q && !i_reset;
  assign bus.o_rd_data       = i_reset ? '0 : (fwd_hit_q ? fwd_data_q : i_rd_data_a);
  assign o_count             = count;
endmodule

// File: doc/regf_write_queue.md
REGF_WRITE_QUEUE -- requirements
Module: regf_write_queue

Interface
REQ-001 Parameters SHALL be: DATA_WDT, default 32, register data width; ADDR_WDT, default 6, register address width; QDEPTH, default 4, queue entries (power of 2, at least 2).
REQ-002 i_clk_2x  in  1  sole clock; reset is synchronous and active-high.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_wr_valid  in  1  write pair offered; i_wr_en_a / i_wr_en_b  in  1 each  per-slot enables.
REQ-005 i_wr_addr_a / i_wr_addr_b  in  ADDR_WDT each; i_wr_data_a / i_wr_data_b  in  DATA_WDT each; o_wr_ready  out  1  queue can accept.
REQ-006 i_rd_valid  in  1 and i_rd_addr  in  ADDR_WDT  read request; o_rd_ready  out  1  read accepted this cycle.
REQ-007 o_rd_data_valid  out  1 and o_rd_data  out  DATA_WDT  read result.
REQ-008 RAM side: o_addr_a, o_addr_b  out  ADDR_WDT; o_wen  out  1; o_wr_data_a, o_wr_data_b  out  DATA_WDT; i_rd_data_a  in  DATA_WDT (1-cycle registered read on port a).
REQ-009 o_count  out  $clog2(QDEPTH)+1  occupied entries.

Function
REQ-010 A pair SHALL be accepted when i_wr_valid and o_wr_ready are both high and at least one slot enable is set; a pair with both enables low SHALL be dropped and SHALL NOT consume an entry.
REQ-011 o_wr_ready SHALL be high iff o_count < QDEPTH; accepting a pair and draining an entry in the same cycle SHALL leave the count unchanged.
REQ-012 When both slots are enabled and i_wr_addr_a equals i_wr_addr_b, the SHALL store only slot b as the pair.
REQ-013 An entry with only one valid slot SHALL drive the same address and data on both RAM ports when issued.
REQ-014 Arbitration SHALL be evaluated each cycle. If the queue is full, drain SHALL win and o_rd_ready SHALL be low. Otherwise a valid read SHALL win. Otherwise a non-empty queue SHALL drain its oldest entry.
REQ-015 A drain cycle SHALL drive o_wen=1 with the oldest entry on the RAM ports, pop it, and decrement o_count.
REQ-016 A read cycle SHALL drive o_wen=0 and o_addr_a=i_rd_addr, and SHALL assert o_rd_ready.
REQ-017 o_rd_data_valid SHALL pulse exactly one cycle after o_rd_ready.
REQ-018 o_rd_data SHALL be taken from the youngest queued write matching i_rd_addr, as snapshotted at the read-issue cycle; within one entry, slot b SHALL take precedence over slot a.
REQ-019 With no match under REQ-018, o_rd_data SHALL be i_rd_data_a.
REQ-020 A pair accepted in the same cycle as a read issue SHALL NOT be forwarded to that read.
REQ-021 Pointers SHALL wrap modulo QDEPTH, and o_count SHALL never exceed QDEPTH or go below 0.
REQ-022 When idle (no read and an empty queue), the block SHALL drive o_wen=0.

Reset
REQ-023 On i_reset the block SHALL clear all entries, pointers and o_count.
REQ-024 While i_reset is high, o_wen, o_rd_ready and o_rd_data_valid SHALL be 0, o_wr_ready SHALL be 1, and the address and data outputs SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard queued writes and any pending read result.

Structure
REQ-026 The entry record SHALL be defined in the shared register-file package, along with the default widths and QDEPTH. The record holds: en_a, en_b, addr_a, addr_b, data_a, data_b.
REQ-027 Entry storage and pointers SHALL be one sub-module, regf_pair_fifo; arbitration and forwarding SHALL stay in regf_write_queue.

Verification
REQ-028 Reset, then write pair (a: r3=0x11, b: r4=0x22), then idle -> one o_wen cycle with addr_a=3/0x11, addr_b=4/0x22, and o_count returns to 0.
REQ-029 Four pairs with no drain possible (a read every cycle except full) -> o_wr_ready=0 at count 4. The next cycle drains with o_rd_ready=0. A fifth pair is accepted only after the count drops to 3.
REQ-030 Queue r5=0xAA, then r5=0xBB, then read r5 before drain -> o_rd_data=0xBB one cycle after o_rd_ready.
REQ-031 Same-address pair (a: r7=0x1, b: r7=0x2), then drain, then read r7 -> RAM sees 0x2 on both ports, and the read returns 0x2.
REQ-032 Pair with en_a only (r9=0x55) -> RAM ports a and b both carry r9/0x55. Pair with both enables low -> o_count unchanged.
REQ-033 Assert reset with 3 entries queued and a read outstanding -> o_count=0, no o_rd_data_valid pulse, o_wen=0, and no queued write reaches the RAM afterwards.
